// File: rtl/uart_rx_param_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and default bit timing.
package uart_rx_param_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    RX_IDLE   = S_IDLE,
    RX_START  = S_START,
    RX_DATA   = S_DATA,
    RX_PARITY = S_PARITY,
    RX_STOP   = S_STOP,
    RX_BREAK  = S_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int HALF_BIT_DEF     = 217;

  function automatic parity_t parity_mode(input bit en, input bit odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

endpackage

// File: rtl/uart_rx_param_sync2ff.sv
// Two-flop synchronizer for an asynchronous level, with a selectable reset value.
module uart_sync2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch rejection, break handling, error flags
// and a one-word valid/ready holding register.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          parity_err_o,
  output logic          frame_err_o,
  output logic          overrun_o,
  output logic          busy_o
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DW + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
  localparam parity_t PMODE = parity_mode(PARITY_EN != 0, PARITY_ODD != 0);

  logic            rx_s;
  rx_state_t       state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [BW-1:0]   bits_reg;
  logic [DW-1:0]   shift_reg;
  logic            perr_reg;
  logic            ferr_reg;
  logic            deliver_reg;
  logic [DW-1:0]   data_reg;
  logic            valid_reg;
  logic            perr_out_reg;
  logic            ferr_out_reg;
  logic            overrun_reg;

  uart_sync2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RX_IDLE;
      cnt_reg      <= '0;
      bits_reg     <= '0;
      shift_reg    <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      deliver_reg  <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      deliver_reg <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          cnt_reg <= '0;
          if (!rx_s) state_reg <= RX_START;
        end
        RX_START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg   <= '0;
            bits_reg  <= '0;
            perr_reg  <= 1'b0;
            state_reg <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == CNT_FULL) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[DW-1:1]};
            bits_reg  <= bits_reg + 1'b1;
            if (bits_reg == LAST_BIT)
              state_reg <= (PMODE == PAR_NONE) ? RX_STOP : RX_PARITY;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt_reg == CNT_FULL) begin
            cnt_reg   <= '0;
            perr_reg  <= (^shift_reg) ^ rx_s ^ (PMODE == PAR_ODD);
            state_reg <= RX_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_reg == CNT_FULL) begin
            cnt_reg     <= '0;
            deliver_reg <= 1'b1;
            ferr_reg    <= ~rx_s;
            state_reg   <= rx_s ? RX_IDLE : RX_BREAK;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_BREAK: begin
          cnt_reg <= '0;
          if (rx_s) state_reg <= RX_IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= RX_IDLE;
        end
      endcase

      // A finished word lands only if the slot is free or being emptied this cycle.
      overrun_reg <= 1'b0;
      if (deliver_reg && (!valid_reg || ready_i)) begin
        data_reg     <= shift_reg;
        perr_out_reg <= perr_reg & (PMODE != PAR_NONE);
        ferr_out_reg <= ferr_reg;
        valid_reg    <= 1'b1;
      end else if (deliver_reg) begin
        overrun_reg <= 1'b1;
      end else if (valid_reg && ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_o       = data_reg;
  assign valid_o      = valid_reg;
  assign parity_err_o = perr_out_reg;
  assign frame_err_o  = ferr_out_reg;
  assign overrun_o    = overrun_reg;
  assign busy_o       = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomized frames against a frame-level reference model for uart_rx_param.
module tb_uart_rx_param;

  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic rst;
  logic rx_i;
  logic ready_i;

  logic [7:0] data_o, pe_data, po_data;
  logic valid_o, perr_o, ferr_o, ovr_o, busy_o;
  logic pe_valid, pe_perr, pe_ferr, pe_ovr, pe_busy;
  logic po_valid, po_perr, po_ferr, po_ovr, po_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;

  logic [7:0] got_data [0:255];
  logic       got_perr [0:255];
  logic       got_ferr [0:255];
  int n_got = 0;
  int rise_cyc = 0;
  int ovr_cnt = 0;
  int vhigh = 0;
  logic valid_prev = 1'b0;

  logic [7:0] pe_d [0:63];
  logic       pe_p [0:63];
  logic [7:0] po_d [0:63];
  logic       po_p [0:63];
  int n_pe = 0;
  int n_po = 0;

  always #5 clk = ~clk;

  uart_rx_param #(.DW(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .parity_err_o(perr_o), .frame_err_o(ferr_o),
    .overrun_o(ovr_o), .busy_o(busy_o)
  );

  uart_rx_param #(.DW(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(pe_data), .valid_o(pe_valid),
    .ready_i(ready_i), .parity_err_o(pe_perr), .frame_err_o(pe_ferr),
    .overrun_o(pe_ovr), .busy_o(pe_busy)
  );

  uart_rx_param #(.DW(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .rst(rst), .rx_i(rx_i), .data_o(po_data), .valid_o(po_valid),
    .ready_i(ready_i), .parity_err_o(po_perr), .frame_err_o(po_ferr),
    .overrun_o(po_ovr), .busy_o(po_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every word the consumer takes, valid rise times and overrun pulses.
  always @(negedge clk) begin
    valid_prev <= valid_o;
    if (valid_o && !valid_prev) rise_cyc <= cyc;
    if (valid_o) vhigh <= vhigh + 1;
    if (ovr_o) ovr_cnt <= ovr_cnt + 1;
    if (valid_o && ready_i) begin
      got_data[n_got[7:0]] <= data_o;
      got_perr[n_got[7:0]] <= perr_o;
      got_ferr[n_got[7:0]] <= ferr_o;
      n_got <= n_got + 1;
    end
    if (pe_valid && ready_i) begin
      pe_d[n_pe[5:0]] <= pe_data;
      pe_p[n_pe[5:0]] <= pe_perr;
      n_pe <= n_pe + 1;
    end
    if (po_valid && ready_i) begin
      po_d[n_po[5:0]] <= po_data;
      po_p[n_po[5:0]] <= po_perr;
      n_po <= n_po + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic pb,
                            input logic stopb);
    @(posedge clk); #1;
    last_start = cyc;
    rx_i = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_i = d[i];
      repeat (C) @(posedge clk);
    end
    if (has_par) begin
      #1 rx_i = pb;
      repeat (C) @(posedge clk);
    end
    #1 rx_i = stopb;
    repeat (C) @(posedge clk);
    #1 rx_i = 1'b1;
  endtask

  // Reference: valid rises one cycle after the stop sample, 3 cycles of input latency.
  function automatic int exp_rise(input int start, input int pbits);
    return start + 3 + H + (9 + pbits) * C + 1;
  endfunction

  function automatic logic par_err(input logic [7:0] d, input logic pb, input logic odd);
    return logic'((($countones(d) + int'(pb)) % 2) != int'(odd));
  endfunction

  int rd = 0;

  task automatic check_next(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe);
    chk({tag, "_count"}, n_got, rd + 1);
    if (n_got > rd) begin
      chk({tag, "_data"}, got_data[rd[7:0]], d);
      chk({tag, "_perr"}, got_perr[rd[7:0]], pe);
      chk({tag, "_ferr"}, got_ferr[rd[7:0]], fe);
    end
    rd = n_got;
  endtask

  initial begin
    logic [7:0] d;
    logic pb, st, seen;
    int rp, ro, v0, o0, gap, dl;

    rst = 1'b1; rx_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_perr", perr_o, 0);
    chk("rst_ferr", ferr_o, 0);
    chk("rst_ovr", ovr_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // Base frame and its exact latency.
    v0 = vhigh;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (2 * C) @(posedge clk);
    check_next("a5", 8'hA5, 1'b0, 1'b0);
    chk("a5_rise", rise_cyc, exp_rise(last_start, 0));
    chk("a5_valid_len", vhigh - v0, 1);

    // Parity receivers: two directed frames then random ones.
    rp = n_pe; ro = n_po;
    for (int k = 0; k < 6; k++) begin
      d  = (k < 2) ? 8'h07 : 8'($urandom_range(0, 255));
      pb = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      send_frame(d, 1'b1, pb, 1'b1);
      repeat (2 * C) @(posedge clk);
      chk("par_even_count", n_pe, rp + 1);
      chk("par_odd_count", n_po, ro + 1);
      chk("par_even_data", pe_d[rp[5:0]], d);
      chk("par_even_perr", pe_p[rp[5:0]], par_err(d, pb, 1'b0));
      chk("par_odd_perr", po_p[ro[5:0]], par_err(d, pb, 1'b1));
      chk("par_odd_data", po_d[ro[5:0]], d);
      rp = n_pe; ro = n_po;
    end
    rd = n_got;

    // Short low pulse: seen as a start, rejected at the half-bit sample.
    @(posedge clk); #1 rx_i = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | busy_o;
      @(posedge clk);
    end
    #1 rx_i = 1'b1;
    for (int i = 0; i < H + 1; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    chk("glitch_busy_seen", seen, 1);
    chk("glitch_busy_clear", busy_o, 0);
    repeat (2 * C) @(posedge clk);
    chk("glitch_no_valid", n_got, rd);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (2 * C) @(posedge clk);
    check_next("after_glitch", 8'h3C, 1'b0, 1'b0);

    // Line held low: one framing-error word, then silence until the line recovers.
    @(posedge clk); #1 rx_i = 1'b0;
    repeat (30 * C) @(posedge clk);
    @(negedge clk);
    chk("break_busy", busy_o, 1);
    check_next("break", 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1 rx_i = 1'b1;
    repeat (2 * C) @(posedge clk);
    chk("break_no_more", n_got, rd);
    chk("break_idle", busy_o, 0);

    // Random frames, random stop bit and inter-frame gaps.
    for (int k = 0; k < 8; k++) begin
      d   = 8'($urandom_range(0, 255));
      st  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(H, 3 * C);
      send_frame(d, 1'b0, 1'b0, st);
      check_next("rand", d, 1'b0, ~st);
      chk("rand_rise", rise_cyc, exp_rise(last_start, 0));
      repeat (gap) @(posedge clk);
    end

    // Backpressure: second word is dropped with a single overrun pulse.
    @(posedge clk); #1 ready_i = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (C) @(posedge clk);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    repeat (C) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_data", data_o, 8'h11);
    chk("bp_hold_valid", valid_o, 1);
    chk("bp_overrun", ovr_cnt - o0, 1);
    chk("bp_nothing_taken", n_got, rd);
    @(posedge clk); #1 ready_i = 1'b1;
    @(posedge clk); #1 ready_i = 1'b0;
    check_next("bp_accept", 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_valid_drop", valid_o, 0);
    chk("bp_data_kept", data_o, 8'h11);

    // Acceptance on the delivery cycle swaps in the new word without overrun.
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (C) @(posedge clk);
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    join_none
    @(posedge clk); #2;
    dl = exp_rise(last_start, 0);
    while (cyc < dl - 1) begin
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1 ready_i = 1'b0;
    check_next("bp2_first", 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp2_data", data_o, 8'h22);
    chk("bp2_valid", valid_o, 1);
    chk("bp2_no_overrun", ovr_cnt, o0);
    repeat (2 * C) @(posedge clk);
    #1 ready_i = 1'b1;
    @(posedge clk); #1;
    check_next("bp2_second", 8'h22, 1'b0, 1'b0);

    // Reset in the middle of a frame while a word is held.
    ready_i = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    repeat (C) @(posedge clk);
    @(negedge clk);
    chk("mid_held", valid_o, 1);
    fork
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    join_none
    @(posedge clk); #2;
    dl = last_start + 3 + H + 3 * C;
    while (cyc < dl) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_flags", {perr_o, ferr_o, ovr_o}, 0);
    rst = 1'b0;
    repeat (8 * C) @(posedge clk);
    #1 ready_i = 1'b1;
    repeat (2) @(posedge clk);
    chk("mid_no_word", n_got, rd);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (2 * C) @(posedge clk);
    check_next("after_rst", 8'h5A, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
